nrzi_decode: RTL and testbench
==============================

# nrzi_decode

Receive-side companion to the transmit NRZI encoder. Takes the sampled line level one bit per strobe, recovers the data bits (no transition = 1, transition = 0), removes the stuffed 0 inserted after every run of STUFF_LEN ones, and flags stuffing violations. Sits between the line sampler and the packet/PID decoder on the receive path.

## Interface
- STUFF_LEN, 6, number of consecutive decoded 1s after which the next bit must be a stuffed 0
- clk  input  1  single system clock, all state on rising edge
- rst_L  input  1  asynchronous, active-low reset
- in_valid  input  1  strobe: `inb` carries a new line sample this cycle
- inb  input  1  sampled line level
- clear  input  1  synchronous restart: return to idle line level 1, zero run count, leave error state
- out_valid  output  1  registered: `out_bit` is a decoded, unstuffed data bit
- out_bit  output  1  registered decoded data bit
- stuff_err  output  1  registered one-cycle pulse: bit after a full run of ones decoded as 1
- err  output  1  sticky error level, high while in ERROR

## Operation
- Reset and clear: the previous-level register is set to 1, the idle level the encoder starts from.
- Decode: `d = ~(inb ^ prev_level)`.
- Each accepted `in_valid` sample updates `prev_level <= inb`, including stuffed bits. Samples taken in ERROR also update it.
- The run counter `ones_cnt` is `$clog2(STUFF_LEN+1)` bits wide and saturates at STUFF_LEN.
- FSM states: ACTIVE, STUFF, ERROR. Reset state is ACTIVE.
- ACTIVE, on in_valid:
  - emit `d`.
  - If `d` = 1, increment `ones_cnt`. Otherwise set `ones_cnt` to 0.
  - When the increment reaches STUFF_LEN, go to STUFF. The bit that completes the run is still emitted.
- STUFF, on in_valid:
  - If `d` = 0, it is a stuffed bit: drop it (no out_valid), set `ones_cnt` to 0, return to ACTIVE.
  - If `d` = 1, pulse stuff_err, emit nothing, go to ERROR.
- ERROR: produce no out_valid. `err` stays 1 until `clear` or reset.
- Cycles without in_valid: state, counter and prev_level hold. A run of ones may span idle cycles.
- `clear` takes priority over `in_valid` in the same cycle. That sample is discarded and not decoded.
- `clear` while idle or in ACTIVE with count 0 has no visible effect.
- A stuffed bit arriving after `clear` is not special: the counter restarts from 0.

## Timing
- Reset values, applied asynchronously on rst_L low: out_valid=0, out_bit=0, stuff_err=0, err=0, prev_level=1, ones_cnt=0, state ACTIVE.
- Latency 1: a sample accepted at edge k produces out_valid/out_bit valid in the cycle after edge k.
- out_valid and stuff_err are single-cycle and deassert on the next edge unless a new sample qualifies. Both are never high in the same cycle.
- Throughput: one sample per cycle, sustained. in_valid may be continuous.
- `err` rises in the same cycle as stuff_err. It falls one cycle after a `clear` edge.
- Reset asserted mid-packet drops all outputs to their reset values immediately. There is no partial-bit state to recover.

## Structure
- Package `nrzi_pkg`:
  - `typedef enum logic [1:0] {ACTIVE, STUFF, ERROR} unstuff_state_t`
  - `localparam IDLE_LEVEL = 1'b1`
  - The encoder side imports the same IDLE_LEVEL.
- Sub-module `bit_unstuff` holds the FSM, run counter and output registers. Its inputs are decoded bit, bit valid and clear.
- The top level holds only the prev_level flop (existing `register` cell, width 1) and the XNOR.

## Test plan
- Basic decode: reset, levels 1,1,0,0,1 on consecutive in_valid -> out_bit 1,1,0,1,0, each one cycle later, err=0.
- Stuff removal: levels 1,1,1,1,1,1 (six 1s), then 0 (stuff), then 0 -> seven out_valid pulses, all out_bit=1; the stuffed sample produces no out_valid; stuff_err never pulses.
- Violation: seven level-1 samples after reset -> six outputs of 1; 7th sample gives stuff_err pulse, err=1, no out_valid. Further samples give no out_valid. `clear`, then levels 0,0 -> out_bit 0,1, err=0.
- Clear collision: mid-run with ones_cnt=4 and prev_level=0, assert clear and in_valid together with inb=0 -> no out_valid. Next sample inb=1 decodes as 1 (prev_level restored to 1), count 1.
- Gapped strobes: same stream as the stuff-removal case with 0-3 idle cycles between samples -> identical out_bit sequence; stuffed bit still dropped.
- Async reset mid-run: assert rst_L low between edges after three 1s -> outputs 0 immediately. Release, then six 1s -> no stuff expected before the 7th sample (count restarted).

Source files
------------

// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI receive path.
// The transmit encoder imports the same idle level.
package nrzi_pkg;

   typedef enum logic [1:0] {
      ACTIVE,
      STUFF,
      ERROR
   } unstuff_state_t;

   // Line level the encoder drives before the first transition.
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_unstuff.sv
// Removes the stuffed 0 after each run of STUFF_LEN decoded ones and flags
// a run that is not followed by a 0. All outputs are registered.
module bit_unstuff
   import nrzi_pkg::*;
#(
   parameter int STUFF_LEN = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic bit_valid_i,
   input  logic bit_i,
   output logic out_valid_o,
   output logic out_bit_o,
   output logic stuff_err_o,
   output logic err_o
);

   localparam int CNT_W = $clog2(STUFF_LEN + 1);

   unstuff_state_t   state_q;
   logic [CNT_W-1:0] ones_cnt_q;
   logic             out_valid_q;
   logic             out_bit_q;
   logic             stuff_err_q;
   logic             err_q;

   // NOTE: every flop here is reset asynchronously; there is no memory, so
   // nothing is left holding stale state when rst_n drops mid-packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACTIVE;
         ones_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         stuff_err_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         stuff_err_q <= 1'b0;
         if (clear_i) begin
            state_q    <= ACTIVE;
            ones_cnt_q <= '0;
            err_q      <= 1'b0;
         end else if (bit_valid_i) begin
            unique case (state_q)
               ACTIVE: begin
                  out_valid_q <= 1'b1;
                  out_bit_q   <= bit_i;
                  if (!bit_i) begin
                     ones_cnt_q <= '0;
                  end else if (ones_cnt_q == CNT_W'(STUFF_LEN - 1)) begin
                     // The bit completing the run is still emitted.
                     ones_cnt_q <= CNT_W'(STUFF_LEN);
                     state_q    <= STUFF;
                  end else begin
                     ones_cnt_q <= ones_cnt_q + 1'b1;
                  end
               end
               STUFF: begin
                  if (!bit_i) begin
                     ones_cnt_q <= '0;
                     state_q    <= ACTIVE;
                  end else begin
                     stuff_err_q <= 1'b1;
                     err_q       <= 1'b1;
                     state_q     <= ERROR;
                  end
               end
               ERROR: begin
                  state_q <= ERROR;
               end
               default: begin
                  state_q <= ERROR;
               end
            endcase
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_bit_o   = out_bit_q;
   assign stuff_err_o = stuff_err_q;
   assign err_o       = err_q;

endmodule

// File: rtl/register.sv
// Generic enabled register with asynchronous active-low reset to a
// parameterised value.
module register #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= RESET_VAL;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/nrzi_decode.sv
// NRZI receive decoder: no transition = 1, transition = 0, followed by
// bit unstuffing and stuffing-violation detection.
module nrzi_decode
   import nrzi_pkg::*;
#(
   parameter int STUFF_LEN = 6
) (
   input  logic clk,
   input  logic rst_L,
   input  logic in_valid,
   input  logic inb,
   input  logic clear,
   output logic out_valid,
   output logic out_bit,
   output logic stuff_err,
   output logic err
);

   logic prev_level;
   logic prev_level_d;
   logic prev_level_en;
   logic dec_bit;

   // Clear restores the idle level and wins over a same-cycle sample.
   assign prev_level_en = in_valid | clear;
   assign prev_level_d  = clear ? IDLE_LEVEL : inb;
   assign dec_bit       = ~(inb ^ prev_level);

   register #(
      .WIDTH     (1),
      .RESET_VAL (IDLE_LEVEL)
   ) u_prev_level (
      .clk   (clk),
      .rst_n (rst_L),
      .en_i  (prev_level_en),
      .d_i   (prev_level_d),
      .q_o   (prev_level)
   );

   bit_unstuff #(
      .STUFF_LEN (STUFF_LEN)
   ) u_bit_unstuff (
      .clk         (clk),
      .rst_n       (rst_L),
      .clear_i     (clear),
      .bit_valid_i (in_valid),
      .bit_i       (dec_bit),
      .out_valid_o (out_valid),
      .out_bit_o   (out_bit),
      .stuff_err_o (stuff_err),
      .err_o       (err)
   );

endmodule

// File: tb/tb_nrzi_decode.sv
// Directed bench for nrzi_decode: a vector table for the single-stream
// cases plus hand-written sequences for clear collision, gaps and reset.
module tb_nrzi_decode;

   logic clk = 1'b0;
   logic rst_L;
   logic in_valid;
   logic inb;
   logic clear;
   logic out_valid;
   logic out_bit;
   logic stuff_err;
   logic err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic iv;
      logic inb;
      logic clr;
      logic ov;
      logic ob;
      logic se;
      logic er;
   } vec_t;

   vec_t vecs[$];

   nrzi_decode #(.STUFF_LEN(6)) dut (
      .clk       (clk),
      .rst_L     (rst_L),
      .in_valid  (in_valid),
      .inb       (inb),
      .clear     (clear),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .stuff_err (stuff_err),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic apply(input logic iv, input logic b, input logic clr);
      in_valid = iv;
      inb      = b;
      clear    = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic ov, input logic ob,
                            input logic se, input logic er);
      check({name, ".out_valid"}, out_valid, ov);
      if (ov) check({name, ".out_bit"}, out_bit, ob);
      check({name, ".stuff_err"}, stuff_err, se);
      check({name, ".err"}, err, er);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      inb      = 1'b0;
      clear    = 1'b0;
      rst_L    = 1'b0;
      @(posedge clk);
      #1;
      rst_L = 1'b1;
   endtask

   function automatic void add(input logic iv, input logic b, input logic clr,
                               input logic ov, input logic ob, input logic se,
                               input logic er);
      vec_t v;
      v.iv = iv; v.inb = b; v.clr = clr;
      v.ov = ov; v.ob = ob; v.se = se; v.er = er;
      vecs.push_back(v);
   endfunction

   initial begin
      // Basic decode from idle level 1: levels 1,1,0,0,1 -> 1,1,0,1,0.
      add(1, 1, 0, 1, 1, 0, 0);
      add(1, 1, 0, 1, 1, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 1, 1, 0, 0);
      add(1, 1, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      // Stuff removal: six 1s, stuffed 0 dropped, then a 1.
      for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0);
      // Violation: seven 1s, error is sticky until clear.
      for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 1, 0, 0);
      add(1, 1, 0, 0, 0, 1, 1);
      add(1, 1, 0, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 1, 1, 0, 0);

      do_reset();
      check_out("reset", 0, 0, 0, 0);
      check("reset.out_bit", out_bit, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].iv, vecs[i].inb, vecs[i].clr);
         check_out($sformatf("tbl[%0d]", i), vecs[i].ov, vecs[i].ob,
                   vecs[i].se, vecs[i].er);
      end

      // Clear collision with ones_cnt=4, prev_level=0.
      do_reset();
      apply(1, 0, 0);
      check_out("coll.pre0", 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         apply(1, 0, 0);
         check_out($sformatf("coll.one%0d", i), 1, 1, 0, 0);
      end
      apply(1, 0, 1);
      check_out("coll.clear", 0, 0, 0, 0);
      apply(1, 1, 0);
      check_out("coll.first", 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         apply(1, 1, 0);
         check_out($sformatf("coll.run%0d", i), 1, 1, 0, 0);
      end
      apply(1, 0, 0);
      check_out("coll.stuffed", 0, 0, 0, 0);
      apply(1, 0, 0);
      check_out("coll.after", 1, 1, 0, 0);

      // Gapped strobes: stuff-removal stream with 0-3 idle cycles between.
      do_reset();
      begin
         logic lv[8];
         int   n_out;
         n_out = 0;
         lv = '{1, 1, 1, 1, 1, 1, 0, 0};
         for (int i = 0; i < 8; i++) begin
            apply(1, lv[i], 0);
            if (out_valid) begin
               n_out++;
               check($sformatf("gap.bit%0d", i), out_bit, 1'b1);
            end
            check($sformatf("gap.valid%0d", i), out_valid, (i != 6));
            check($sformatf("gap.se%0d", i), stuff_err, 1'b0);
            for (int g = 0; g < (i % 4); g++) begin
               apply(0, ~lv[i], 0);
               check($sformatf("gap.idle%0d_%0d", i, g), out_valid, 1'b0);
            end
         end
         tests++;
         if (n_out != 7) begin
            fails++;
            $display("FAIL gap.count: got %0d outputs expected 7", n_out);
         end
      end

      // Async reset mid-run, applied between edges.
      do_reset();
      for (int i = 0; i < 3; i++) apply(1, 1, 0);
      check("areset.pre", out_valid, 1'b1);
      #2 rst_L = 1'b0;
      #1;
      check_out("areset.now", 0, 0, 0, 0);
      check("areset.bit", out_bit, 1'b0);
      @(posedge clk);
      #1 rst_L = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         apply(1, 1, 0);
         check_out($sformatf("areset.run%0d", i), 1, 1, 0, 0);
      end
      apply(1, 0, 0);
      check_out("areset.stuffed", 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
